// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing controller for the processor datapath.
// Each instruction is stepped through fetch, decode, execute, memory and
// write-back states. One memory port serves both instruction fetch and
// data access, and the memory ready handshake stalls the sequence.
module multicycle_controller #(
  parameter logic [5:0] OPC_R   = 6'd0,
  parameter logic [5:0] OPC_LW  = 6'd1,
  parameter logic [5:0] OPC_SW  = 6'd2,
  parameter logic [5:0] OPC_BEQ = 6'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_op,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH
  } state_t;

  state_t state_q, state_d;

  // State register; reset forces FETCH immediately, abandoning any instruction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of block evaluation order.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    // NOTE: every output and the next state get a default first; any path
    // that leaves one unassigned would otherwise infer a latch.
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_op      = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // PC+4 is computed by the ALU while the instruction is read.
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC loads wait for the memory, and never happen while
        // reset is held even if memory reports ready.
        IRWrite = mem_ready & ~rst;
        PCWrite = mem_ready & ~rst;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Branch target (PC + imm<<2) is computed speculatively into ALUOut.
        ALUSrcB = 2'b11;
        if (opcode == OPC_R && func <= 6'd3)        state_d = S_EXEC_R;
        else if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_ADDR;
        else if (opcode == OPC_BEQ)                 state_d = S_BRANCH;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALU_op  = func[1:0];
        state_d = S_WB_R;
      end

      S_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDR: begin
        // Effective address = reg A + sign-extended immediate.
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OPC_LW)      state_d = S_MEM_RD;
        else if (opcode == OPC_SW) state_d = S_MEM_WR;
        else                       state_d = S_FETCH;
      end

      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end

      S_WB_MEM: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end

      S_BRANCH: begin
        // Subtract to compare; the PC loads the target only on ALU zero.
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b00;
        ALU_op      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes the
// hand-computed output vector expected for each cycle it drives, and a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA, instr_done, illegal;
  logic [1:0] ALUSrcB, ALU_op;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .func        (func),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALU_op      (ALU_op),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout:
  // {PCWrite,PCWriteCond,PCSource,IorD}_{MemRead,MemWrite,IRWrite}_
  // {RegDst,MemToReg,RegWrite}_{ALUSrcA}_{ALUSrcB}_{ALU_op}_{instr_done,illegal}
  logic [16:0] act;
  assign act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALU_op,
                instr_done, illegal};

  localparam logic [16:0] V_FETCH_RDY  = 17'b1000_101_000_0_01_00_00;
  localparam logic [16:0] V_FETCH_WAIT = 17'b0000_100_000_0_01_00_00; // also reset
  localparam logic [16:0] V_DECODE     = 17'b0000_000_000_0_11_00_00;
  localparam logic [16:0] V_DECODE_ILL = 17'b0000_000_000_0_11_00_01;
  localparam logic [16:0] V_EXEC_F0    = 17'b0000_000_000_1_00_00_00;
  localparam logic [16:0] V_EXEC_F2    = 17'b0000_000_000_1_00_10_00;
  localparam logic [16:0] V_EXEC_F3    = 17'b0000_000_000_1_00_11_00;
  localparam logic [16:0] V_WB_R       = 17'b0000_000_101_0_00_00_10;
  localparam logic [16:0] V_ADDR       = 17'b0000_000_000_1_10_00_00;
  localparam logic [16:0] V_MEM_RD     = 17'b0001_100_000_0_00_00_00;
  localparam logic [16:0] V_WB_MEM     = 17'b0000_000_011_0_00_00_10;
  localparam logic [16:0] V_MEM_WR_WT  = 17'b0001_010_000_0_00_00_00;
  localparam logic [16:0] V_MEM_WR_RDY = 17'b0001_010_000_0_00_00_10;
  localparam logic [16:0] V_BRANCH     = 17'b0110_000_000_1_00_01_10;

  typedef struct {
    logic [16:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  end

  // Drive one cycle of stimulus and queue its expected outputs.
  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic cycle(input logic mr, input logic [5:0] op, input logic [5:0] fn,
                       input logic [16:0] want, input string name);
    sb_entry_t e;
    mem_ready = mr;
    opcode    = op;
    func      = fn;
    e.exp  = want;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    sb_entry_t e;
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'd0;
    func      = 6'd0;

    // Reset values while rst is held, mem_ready=1 must not leak to IRWrite/PCWrite.
    e.exp = V_FETCH_WAIT; e.name = "reset_state";
    sb_q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // R-type func=2.
    cycle(1'b1, 6'd0, 6'd2, V_FETCH_RDY, "r2_fetch");
    cycle(1'b1, 6'd0, 6'd2, V_DECODE,    "r2_decode");
    cycle(1'b1, 6'd0, 6'd2, V_EXEC_F2,   "r2_exec");
    cycle(1'b1, 6'd0, 6'd2, V_WB_R,      "r2_wb");

    // R-type func=3, upper legal func value.
    cycle(1'b1, 6'd0, 6'd3, V_FETCH_RDY, "r3_fetch");
    cycle(1'b1, 6'd0, 6'd3, V_DECODE,    "r3_decode");
    cycle(1'b1, 6'd0, 6'd3, V_EXEC_F3,   "r3_exec");
    cycle(1'b1, 6'd0, 6'd3, V_WB_R,      "r3_wb");

    // LW with three wait cycles in MEM_RD.
    cycle(1'b1, 6'd1, 6'd0, V_FETCH_RDY, "lw_fetch");
    cycle(1'b1, 6'd1, 6'd0, V_DECODE,    "lw_decode");
    cycle(1'b1, 6'd1, 6'd0, V_ADDR,      "lw_addr");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 6'd1, 6'd0, V_MEM_RD,  "lw_memrd_wait");
    cycle(1'b1, 6'd1, 6'd0, V_MEM_RD,    "lw_memrd_rdy");
    cycle(1'b1, 6'd1, 6'd0, V_WB_MEM,    "lw_wb");

    // SW with mem_ready=1.
    cycle(1'b1, 6'd2, 6'd0, V_FETCH_RDY,  "sw_fetch");
    cycle(1'b1, 6'd2, 6'd0, V_DECODE,     "sw_decode");
    cycle(1'b1, 6'd2, 6'd0, V_ADDR,       "sw_addr");
    cycle(1'b1, 6'd2, 6'd0, V_MEM_WR_RDY, "sw_memwr");

    // BEQ.
    cycle(1'b1, 6'd3, 6'd0, V_FETCH_RDY, "beq_fetch");
    cycle(1'b1, 6'd3, 6'd0, V_DECODE,    "beq_decode");
    cycle(1'b1, 6'd3, 6'd0, V_BRANCH,    "beq_branch");

    // Illegal opcode 7, then R-type with func=5 and func=4.
    cycle(1'b1, 6'd7, 6'd0, V_FETCH_RDY,  "ill7_fetch");
    cycle(1'b1, 6'd7, 6'd0, V_DECODE_ILL, "ill7_decode");
    cycle(1'b1, 6'd0, 6'd5, V_FETCH_RDY,  "illf5_fetch");
    cycle(1'b1, 6'd0, 6'd5, V_DECODE_ILL, "illf5_decode");
    cycle(1'b1, 6'd0, 6'd4, V_FETCH_RDY,  "illf4_fetch");
    cycle(1'b1, 6'd0, 6'd4, V_DECODE_ILL, "illf4_decode");

    // FETCH stalled five cycles, then R-type func=0.
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 6'd0, 6'd0, V_FETCH_WAIT, "fetch_wait");
    cycle(1'b1, 6'd0, 6'd0, V_FETCH_RDY, "r0_fetch");
    cycle(1'b1, 6'd0, 6'd0, V_DECODE,    "r0_decode");
    cycle(1'b1, 6'd0, 6'd0, V_EXEC_F0,   "r0_exec");
    cycle(1'b1, 6'd0, 6'd0, V_WB_R,      "r0_wb");

    // SW stalled in MEM_WR, then asynchronous reset mid-cycle.
    cycle(1'b1, 6'd2, 6'd0, V_FETCH_RDY, "swr_fetch");
    cycle(1'b1, 6'd2, 6'd0, V_DECODE,    "swr_decode");
    cycle(1'b1, 6'd2, 6'd0, V_ADDR,      "swr_addr");
    cycle(1'b0, 6'd2, 6'd0, V_MEM_WR_WT, "swr_memwr_wait");
    mem_ready = 1'b0;
    #1;
    rst = 1'b1;
    e.exp = V_FETCH_WAIT; e.name = "async_rst_mid_cycle";
    sb_q.push_back(e);
    @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    e.exp = V_FETCH_WAIT; e.name = "rst_held_ready";
    sb_q.push_back(e);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 6'd2, 6'd0, V_FETCH_RDY,  "post_rst_fetch");
    cycle(1'b1, 6'd2, 6'd0, V_DECODE,     "post_rst_decode");
    cycle(1'b1, 6'd2, 6'd0, V_ADDR,       "post_rst_addr");
    cycle(1'b1, 6'd2, 6'd0, V_MEM_WR_RDY, "post_rst_memwr");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
